car_sensor: RTL
===============

CAR_SENSOR -- requirements
Module: car_sensor

Interface
REQ-001 Parameter DEBOUNCE, default 4, number of consecutive clk cycles a synchronized level must hold to be accepted (legal range 2..255).
REQ-002 Parameter MAX_CARS, default 15, saturation value of the waiting-car counter (legal range 1..15).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 sensor_raw  input  1  asynchronous, bouncing country-road vehicle loop; high = vehicle present.
REQ-006 serve  input  1  one-cycle pulse from the downstream traffic controller; one waiting car has been given green.
REQ-007 car  output  1  level; high while at least one car is waiting; drives the controller car input.
REQ-008 car_count  output  4  number of waiting cars, 0..MAX_CARS.
REQ-009 arrival  output  1  one-cycle pulse per accepted vehicle arrival.
REQ-010 overflow  output  1  sticky flag; an arrival was lost at saturation.

Function
REQ-011 Input SHALL pass a 2-flop synchronizer (sync1 <= sensor_raw; sync2 <= sync1); only sync2 feeds the FSM.
REQ-012 Debounce FSM SHALL have states IDLE, PRESS_CHK, ACTIVE, REL_CHK with an 8-bit counter cnt.
REQ-013 IDLE: sync2=1 -> PRESS_CHK, cnt<=1; else stay, cnt<=0.
REQ-014 PRESS_CHK: sync2=0 -> IDLE, cnt<=0; sync2=1 and cnt=DEBOUNCE-1 -> ACTIVE, cnt<=0; else cnt<=cnt+1.
REQ-015 ACTIVE: sync2=0 -> REL_CHK, cnt<=1; else stay.
REQ-016 REL_CHK: sync2=1 -> ACTIVE, cnt<=0; sync2=0 and cnt=DEBOUNCE-1 -> IDLE, cnt<=0; else cnt<=cnt+1.
REQ-017 arrival SHALL be a registered pulse, high for exactly the one cycle after the PRESS_CHK->ACTIVE edge; no other transition asserts it.
REQ-018 Latency: sensor_raw first sampled high at edge 1 and held -> arrival high after edge DEBOUNCE+2 (edge 6 at default).
REQ-019 A high pulse on sync2 shorter than DEBOUNCE cycles SHALL produce no arrival; a low glitch shorter than DEBOUNCE cycles during ACTIVE SHALL NOT end the vehicle and SHALL NOT cause a second arrival.
REQ-020 car_count SHALL update on the same edge that raises arrival: +1 on accepted arrival, -1 on serve.
REQ-021 Arrival and serve on the same edge: car_count unchanged, including at 0 and MAX_CARS; overflow unchanged.
REQ-022 serve with car_count=0 and no arrival: ignored, car_count stays 0.
REQ-023 Arrival without serve at car_count=MAX_CARS: car_count stays MAX_CARS, overflow <= 1.
REQ-024 overflow SHALL stay set until rst.
REQ-025 car SHALL be combinational (car_count != 0), no added latency.
REQ-026 Vehicle release (ACTIVE->REL_CHK->IDLE) SHALL NOT change car_count; only serve decrements.

Reset
REQ-027 rst high at an edge: sync1, sync2, cnt <= 0; state <= IDLE; car_count <= 0; arrival <= 0; overflow <= 0; car therefore 0.
REQ-028 rst SHALL take priority over all other inputs, including mid-debounce and simultaneous arrival/serve; a level already high on sensor_raw after rst deasserts SHALL be re-debounced from IDLE and counted once.

Verification
REQ-029 rst, sensor_raw held high from edge 1 (DEBOUNCE=4) -> arrival single pulse after edge 6, car_count 0->1, car=1; no further arrival while held.
REQ-030 sensor_raw bounces 1,0,1,1,0 then stays low -> no arrival, car_count=0, FSM back in IDLE.
REQ-031 Three clean arrivals, then three serve pulses spaced 10 cycles -> car_count 1,2,3 then 2,1,0; car drops to 0 on the edge of the third serve; fourth serve -> count stays 0.
REQ-032 Sixteen clean arrivals (MAX_CARS=15) -> car_count saturates at 15, overflow=1 after 16th arrival and remains 1 after subsequent serves.
REQ-033 serve pulse on exactly the arrival edge with car_count=2 -> car_count stays 2; same with car_count=0 -> stays 0, car stays 0.
REQ-034 rst asserted while in PRESS_CHK with cnt=2 and car_count=5 -> next cycle all outputs 0; sensor_raw still high -> new arrival DEBOUNCE+2 edges after rst release counts car_count 0->1.

Source files
------------

// File: rtl/car_sensor.sv
// Country-road vehicle loop front end: synchronizes and debounces the raw loop,
// emits one arrival pulse per vehicle and keeps a saturating waiting-car count.
module car_sensor #(
    parameter int unsigned DEBOUNCE = 4,
    parameter int unsigned MAX_CARS = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sensor_raw,
    input  logic       serve,
    output logic       car,
    output logic [3:0] car_count,
    output logic       arrival,
    output logic       overflow
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        ACTIVE    = 2'd2,
        REL_CHK   = 2'd3
    } state_t;

    localparam logic [7:0] CNT_LAST  = 8'(DEBOUNCE - 1);
    localparam logic [3:0] COUNT_MAX = 4'(MAX_CARS);

    logic       sync1_q, sync2_q;
    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       arrival_q, arrival_d;
    logic [3:0] count_q, count_d;
    logic       overflow_q, overflow_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sensor_raw;
            sync2_q <= sync1_q;
        end
    end

    // Debounce FSM; arrival_d is high only on the PRESS_CHK->ACTIVE edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        arrival_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sync2_q) begin
                    state_d = PRESS_CHK;
                    cnt_d   = 8'd1;
                end else begin
                    cnt_d   = 8'd0;
                end
            end
            PRESS_CHK: begin
                if (!sync2_q) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ACTIVE;
                    cnt_d     = 8'd0;
                    arrival_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ACTIVE: begin
                if (!sync2_q) begin
                    state_d = REL_CHK;
                    cnt_d   = 8'd1;
                end
            end
            REL_CHK: begin
                if (sync2_q) begin
                    state_d = ACTIVE;
                    cnt_d   = 8'd0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Simultaneous arrival and serve cancel; an arrival at saturation is lost.
    always_comb begin
        count_d    = count_q;
        overflow_d = overflow_q;
        if (arrival_d && !serve) begin
            if (count_q == COUNT_MAX) begin
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + 4'd1;
            end
        end else if (serve && !arrival_d && count_q != 4'd0) begin
            count_d = count_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            arrival_q  <= 1'b0;
            count_q    <= 4'd0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            arrival_q  <= arrival_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign car       = (count_q != 4'd0);
    assign car_count = count_q;
    assign arrival   = arrival_q;
    assign overflow  = overflow_q;

endmodule
